// File: rtl/word_tx_if.sv
// Word transmitter bus: parallel word and send request in, serial line and status out.
interface word_tx_if;
  logic [15:0] din;
  logic        send;
  logic        txd;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  // Requester side: supplies the word and the debounced key level
  modport master (
    output din,
    output send,
    input  txd,
    input  busy,
    input  done,
    input  sout
  );

  // Transmitter side
  modport slave (
    input  din,
    input  send,
    output txd,
    output busy,
    output done,
    output sout
  );
endinterface

// File: rtl/word_tx.sv
// 16-bit word serialiser: start bit, 16 data bits LSB first, stop bit.
// One frame per key press; the key must be released before the next frame.
module word_tx #(
  parameter logic [15:0] BIT_CYC = 16'd50000,
  parameter logic [7:0]  BIT_NUM = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  word_tx_if.slave   bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_W  = 4;
  localparam int unsigned DATA_W = 16;

  localparam logic [CNT_W-1:0] CNT_LAST = BIT_CYC - 16'd1;
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(BIT_NUM - 8'd1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_STRT = 3'd2,
    S_DATA = 3'd3,
    S_STOP = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_W-1:0]    num_q;
  logic [DATA_W-1:0]   sh_q;
  logic                txd_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   sout_q;
  logic                bit_end;

  // Last cycle of the current bit period
  assign bit_end = (cnt_q == CNT_LAST);

  // Frame sequencer with registered line, status and bit-index outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_PREP;
          cnt_q   <= '0;
          num_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          sout_q  <= '0;
        end
        S_PREP: begin
          if (bus.send) begin
            state_q <= S_STRT;
            sh_q    <= bus.din;
            cnt_q   <= '0;
            num_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_STRT: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            txd_q   <= sh_q[0];
            sout_q  <= DATA_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (num_q == NUM_LAST) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
              sout_q  <= '0;
            end else begin
              num_q  <= num_q + NUM_W'(1);
              sh_q   <= sh_q >> 1;
              txd_q  <= sh_q[1];
              sout_q <= DATA_W'(1) << (num_q + NUM_W'(1));
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // Wait for key release so a held key yields a single frame
          if (!bus.send) begin
            state_q <= S_PREP;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          num_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          sout_q  <= '0;
        end
      endcase
    end
  end

  assign bus.txd  = txd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sout = sout_q;

endmodule

// File: tb/tb_word_tx.sv
// Bench for word_tx with BIT_CYC=4: directed frames plus randomized frames
// compared cycle by cycle against a frame-offset reference model.
module tb_word_tx;

  localparam int BC    = 4;
  localparam int FRAME = 18 * BC;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  word_tx_if bus ();

  word_tx #(
    .BIT_CYC (16'd4),
    .BIT_NUM (8'h10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // One comparison point
  task automatic chk(input string tag, input int k, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d got=%h expected=%h", tag, k, got, exp);
    end
  endtask

  // Expected outputs at frame offset k (k=0 is the first start-bit cycle; k<0 means idle)
  task automatic model(input int k, input logic [15:0] d,
                       output logic etxd, output logic ebusy, output logic edone,
                       output logic [15:0] esout);
    int idx;
    etxd  = 1'b1;
    ebusy = 1'b0;
    esout = 16'h0000;
    if (k >= 0 && k < FRAME) begin
      ebusy = 1'b1;
      if (k < BC) begin
        etxd = 1'b0;
      end else if (k < 17 * BC) begin
        idx   = (k - BC) / BC;
        etxd  = d[4'(idx)];
        esout = 16'h0001 << idx;
      end
    end
    edone = (k == FRAME);
  endtask

  task automatic sample(input int k, input logic [15:0] d);
    logic et, eb, ed;
    logic [15:0] es;
    model(k, d, et, eb, ed, es);
    chk("txd",  k, 16'(bus.txd),  16'(et));
    chk("busy", k, 16'(bus.busy), 16'(eb));
    chk("done", k, 16'(bus.done), 16'(ed));
    chk("sout", k, bus.sout, es);
  endtask

  // Idle cycles with send low; DUT must show idle outputs
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(-1, 16'h0000);
      bus.send = 1'b0;
    end
  endtask

  // One frame, entered with the DUT waiting in PREP right after a negedge.
  // hold: cycles send stays high; noisy: random send/din during frame;
  // abort_at: offset at which rst is raised (-1 none); chg_k/chg_val: din change.
  task automatic frame(input logic [15:0] d, input int hold, input bit noisy,
                       input int abort_at, input int chg_k, input logic [15:0] chg_val);
    int last;
    bus.din  = d;
    bus.send = 1'b1;
    last = (hold + 1 > FRAME) ? hold + 1 : FRAME;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (abort_at >= 0 && k == abort_at + 1) begin
        sample(-1, d);
        rst      = 1'b0;
        bus.send = 1'b0;
        break;
      end
      sample(k, d);
      if (k + 1 < hold)
        bus.send = 1'b1;
      else if (noisy && k < FRAME - 2)
        bus.send = 1'($urandom);
      else
        bus.send = 1'b0;
      if (noisy)
        bus.din = 16'($urandom);
      if (k == chg_k)
        bus.din = chg_val;
      if (k == abort_at)
        rst = 1'b1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.send = 1'b0;
    bus.din  = 16'h0000;

    // Reset dominates a random send level
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(-1, 16'h0000);
      bus.send = 1'($urandom);
      bus.din  = 16'($urandom);
    end
    rst      = 1'b0;
    bus.send = 1'b0;
    idle(3);

    // Short press with a mixed word
    frame(16'hA5C3, 3, 1'b0, -1, -1, 16'h0000);
    idle(2);

    // Key held for 200 cycles: one frame only, then a second press
    frame(16'hFFFF, 200, 1'b0, -1, -1, 16'h0000);
    idle(2);
    frame(16'hFFFF, 5, 1'b0, -1, -1, 16'h0000);
    idle(2);

    // din changes during bit 3
    frame(16'h0001, 2, 1'b0, -1, 17, 16'h8000);
    idle(2);

    // Reset during bit 7 aborts without done
    frame(16'h5A3C, 2, 1'b0, 33, -1, 16'h0000);
    idle(4);

    // All-zero word
    frame(16'h0000, 1, 1'b0, -1, -1, 16'h0000);
    idle(2);

    // Randomized frames with key bounce and din noise
    for (int n = 0; n < 8; n++) begin
      frame(16'($urandom), int'($urandom_range(1, 120)), 1'b1, -1, -1, 16'h0000);
      idle(int'($urandom_range(1, 3)));
    end

    // Randomized abort point
    frame(16'($urandom), 2, 1'b1, int'($urandom_range(0, 70)), -1, 16'h0000);
    idle(4);
    frame(16'($urandom), 3, 1'b1, -1, -1, 16'h0000);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/word_tx.md
WORD_TX -- requirements
Module: word_tx

Interface
REQ-001 The module SHALL have parameter BIT_CYC, default 16'd50000, giving clock cycles per serial bit; legal range 2..65535.
REQ-002 The module SHALL have parameter BIT_NUM, default 8'h10, giving the data bits per frame; it is fixed at 16 for this block.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single system clock, with all logic on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-005 Port din SHALL be an input, 16 bits wide: the word to transmit, sampled only at frame start.
REQ-006 Port send SHALL be an input, 1 bit wide: the debounced key level (fs from the key debouncer), active-high.
REQ-007 Port txd SHALL be an output, 1 bit wide: the serial line, idle high.
REQ-008 Port busy SHALL be an output, 1 bit wide: high from the start bit through the stop bit inclusive.
REQ-009 Port done SHALL be an output, 1 bit wide: a 1-cycle pulse at the end of the stop bit.
REQ-010 Port sout SHALL be an output, 16 bits wide: one-hot index of the data bit currently on txd, and 16'h0000 outside the DATA state.

Function
REQ-011 The FSM SHALL have states IDLE, PREP, STRT, DATA, STOP, HOLD, and any unused encoding SHALL go to IDLE.
REQ-012 IDLE SHALL go to PREP unconditionally after one cycle.
REQ-013 PREP SHALL go to STRT when send=1, and SHALL latch din into the shift register on the same edge.
REQ-014 STRT SHALL drive txd=0 for exactly BIT_CYC cycles, then go to DATA.
REQ-015 DATA SHALL send 16 bits LSB first, each held BIT_CYC cycles, with bit index num counting 0..15.
REQ-016 After bit 15, DATA SHALL go to STOP.
REQ-017 STOP SHALL drive txd=1 for BIT_CYC cycles, then go to HOLD.
REQ-018 done SHALL be asserted for the single cycle in which STOP exits.
REQ-019 HOLD SHALL go to PREP only when send=0, so that one key press gives one frame.
REQ-020 A send held high through the whole frame SHALL NOT retrigger a frame.
REQ-021 txd, busy, done and sout SHALL be registered and SHALL change on the same edge as the state change.
REQ-022 Latency: if send is high at the PREP sampling edge E, txd SHALL fall at E+1.
REQ-023 The total frame SHALL be 18*BIT_CYC cycles with busy=1.
REQ-024 The bit-period counter SHALL be 16 bits wide, count 0..BIT_CYC-1, and wrap to 0 on each bit boundary.
REQ-025 num SHALL be 4 bits wide and SHALL be cleared on entry to STRT.
REQ-026 Changes on din during a frame SHALL NOT alter the frame in progress.
REQ-027 sout SHALL equal 16'h0001 << num while in DATA.
REQ-028 send toggling during STRT, DATA or STOP SHALL be ignored.
REQ-029 busy SHALL be 0 in IDLE, PREP and HOLD.

Reset
REQ-030 When rst=1 at a clock edge, the next state SHALL be IDLE, with txd=1, busy=0, done=0, sout=16'h0000, counters=0 and the shift register=0.
REQ-031 rst asserted mid-frame SHALL abort the frame immediately; txd SHALL return high on the next edge with no done pulse.
REQ-032 After rst deasserts, the block SHALL pass IDLE then PREP, and SHALL start a frame only on a subsequent send=1.
REQ-033 rst SHALL take priority over all other inputs.

Verification (BIT_CYC=4)
REQ-034 Directed test: din=16'hA5C3, pulse send high for 3 cycles -> txd low for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy high for 72 cycles; one done pulse.
REQ-035 Directed test: hold send high for 200 cycles with din=16'hFFFF -> exactly one frame is sent; the block stays in HOLD until send=0, and a second press sends a second frame.
REQ-036 Directed test: change din from 16'h0001 to 16'h8000 during bit 3 -> the transmitted frame still carries 16'h0001.
REQ-037 Directed test: assert rst during bit 7 -> txd=1, busy=0, sout=0 one cycle later, and no done pulse.
REQ-038 Directed test: check sout during the data bits -> sout steps 16'h0001, 16'h0002, ..., 16'h8000, each for 4 cycles, and is 0 during the start and stop bits.
REQ-039 Directed test: din=16'h0000 -> txd low for 68 cycles then high for 4 cycles; done pulses at cycle 72 of the frame.
